// File: rtl/id_pkg.sv
// Shared ID-stage definitions: opcode constants, instruction field positions and FSM states.
package id_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned RD_W    = 3;
    localparam int unsigned RS_W    = 3;
    localparam int unsigned RT_W    = 4;

    localparam int unsigned OPC_LSB = 10;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_NOP    = 4'd0;
    localparam logic [OPC_W-1:0] OP_HALT   = 4'd1;
    localparam logic [OPC_W-1:0] OP_LOOP   = 4'd2;
    localparam logic [OPC_W-1:0] OP_ILL_LO = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_JUMP,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } id_state_e;

    // Opcodes 12..15 form the reserved range.
    function automatic logic op_is_illegal(input logic [OPC_W-1:0] op);
        return op >= OP_ILL_LO;
    endfunction

endpackage

// File: rtl/id_loop_counter.sv
// Pass counter for block-repeat loops; a zero load counts as a single pass.
module id_loop_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             is_last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (count_i == '0) ? CNT_W'(1) : count_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_last_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/etapa_id.sv
// ID stage: steers the fetch PC to an algorithm base, then decodes ROM words with 1-cycle latency.
// Build option ID_ILLEGAL_TRAP_EN: opcodes 12..15 raise a sticky err and end the run.
module etapa_id
    import id_pkg::*;
#(
    parameter int unsigned INSTR_W = 14,
    parameter int unsigned ALG_W   = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ALG_W-1:0]   alg_sel,
    input  logic [CNT_W-1:0]   block_count,
    input  logic [INSTR_W-1:0] instruccion,
    input  logic               stall,
    output logic               sel_pc,
    output logic [ALG_W-1:0]   sel_dir,
    output logic               pc_stall,
    output logic [OPC_W-1:0]   opcode,
    output logic [RD_W-1:0]    rd,
    output logic [RS_W-1:0]    rs,
    output logic [RT_W-1:0]    rt,
    output logic               dec_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    id_state_e        state_q, state_d;
    logic [ALG_W-1:0] alg_q, alg_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [RS_W-1:0]  rs_q, rs_d;
    logic [RT_W-1:0]  rt_q, rt_d;
    logic             dec_valid_q, dec_valid_d;
    logic             sel_pc_q, sel_pc_d;
    logic [ALG_W-1:0] sel_dir_q, sel_dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load, cnt_dec, cnt_last;
    logic [OPC_W-1:0] op_c;
`ifdef ID_ILLEGAL_TRAP_EN
    logic             err_q, err_d;
`endif

    assign op_c = instruccion[OPC_LSB +: OPC_W];

    id_loop_counter #(
        .CNT_W(CNT_W)
    ) u_loop_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (cnt_load),
        .dec_i    (cnt_dec),
        .count_i  (block_count),
        .is_last_o(cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        alg_d       = alg_q;
        opcode_d    = opcode_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        dec_valid_d = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_JUMP;
                    alg_d    = alg_sel;
                    cnt_load = 1'b1;
`ifdef ID_ILLEGAL_TRAP_EN
                    err_d    = 1'b0;
`endif
                end
            end
            ST_JUMP: state_d = ST_FILL;
            ST_FILL: state_d = ST_RUN;
            ST_RUN: begin
                if (stall) begin
                    dec_valid_d = dec_valid_q;
                end else begin
                    opcode_d = op_c;
                    rd_d     = instruccion[RD_LSB +: RD_W];
                    rs_d     = instruccion[RS_LSB +: RS_W];
                    rt_d     = instruccion[RT_LSB +: RT_W];
                    if (op_c == OP_HALT) begin
                        state_d = ST_DONE;
                    end else if (op_c == OP_LOOP) begin
                        // Last pass: LOOP falls through like a NOP.
                        if (!cnt_last) begin
                            cnt_dec = 1'b1;
                            state_d = ST_JUMP;
                        end
`ifdef ID_ILLEGAL_TRAP_EN
                    end else if (op_is_illegal(op_c)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
`endif
                    end else if (op_c != OP_NOP) begin
                        dec_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        sel_pc_d  = (state_d == ST_JUMP);
        sel_dir_d = (state_d == ST_JUMP) ? alg_d : '0;
        busy_d    = state_d inside {ST_JUMP, ST_FILL, ST_RUN};
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alg_q       <= '0;
            opcode_q    <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            dec_valid_q <= 1'b0;
            sel_pc_q    <= 1'b0;
            sel_dir_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            alg_q       <= alg_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            dec_valid_q <= dec_valid_d;
            sel_pc_q    <= sel_pc_d;
            sel_dir_q   <= sel_dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Combinational so the PC freezes in the same cycle the hazard appears.
    assign pc_stall  = (state_q == ST_RUN) && stall;
    assign sel_pc    = sel_pc_q;
    assign sel_dir   = sel_dir_q;
    assign opcode    = opcode_q;
    assign rd        = rd_q;
    assign rs        = rs_q;
    assign rt        = rt_q;
    assign dec_valid = dec_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/etapa_id.md
ETAPA_ID -- requirements
Module: etapa_id

Interface
REQ-001 SHALL have parameter INSTR_W, default 14, instruction word width.
REQ-002 SHALL have parameter ALG_W, default 3, algorithm selector width.
REQ-003 SHALL have parameter CNT_W, default 8, block-count width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  request to run an algorithm; sampled only in IDLE.
REQ-007 SHALL have port alg_sel  in  ALG_W  algorithm index (0 = encrypt_xor … 7 = decrypt_add), latched on accepted start.
REQ-008 SHALL have port block_count  in  CNT_W  number of passes, latched on accepted start.
REQ-009 SHALL have port instruccion  in  INSTR_W  word from instruction ROM; one-cycle synchronous-read lag behind PC.
REQ-010 SHALL have port stall  in  1  downstream hazard; freezes decode.
REQ-011 SHALL have port sel_pc  out  1  1 = load PC from algorithm base, 0 = PC+1.
REQ-012 SHALL have port sel_dir  out  ALG_W  base-address select to fetch mux.
REQ-013 SHALL have port pc_stall  out  1  freeze PC register.
REQ-014 SHALL have ports opcode out 4, rd out 3, rs out 3, rt out 4  registered decoded fields [13:10], [9:7], [6:4], [3:0].
REQ-015 SHALL have ports dec_valid out 1, busy out 1, done out 1, err out 1.

Function
REQ-016 SHALL implement FSM states IDLE, JUMP, FILL, RUN, DONE.
REQ-017 IDLE: busy=0, sel_pc=0; start=1 latches alg_sel and block_count, goes to JUMP; start while not IDLE SHALL be ignored.
REQ-018 JUMP: sel_pc=1, sel_dir=latched alg, one cycle, then FILL.
REQ-019 FILL: one cycle, instruccion ignored (stale), dec_valid=0, then RUN.
REQ-020 RUN: opcode fields registered from instruccion with 1-cycle latency; dec_valid=1 next cycle for any opcode except NOP(0), HALT(1), LOOP(2).
REQ-021 HALT in RUN: go to DONE; no further words decoded.
REQ-022 LOOP in RUN: if pass counter > 1, decrement and go to JUMP (re-fetch same base); else behave as NOP and continue.
REQ-023 block_count = 0 SHALL be treated as 1 (single pass).
REQ-024 stall=1 in RUN: pc_stall=1, decoded outputs and dec_valid held, FSM and counter held; stall ignored in other states (pc_stall=0).
REQ-025 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-026 busy=1 in JUMP, FILL, RUN.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, and all outputs 0, including mid-run.
REQ-028 First accepted start SHALL be the first edge after rst_n deasserts with start=1.

Configuration
REQ-029 With ID_ILLEGAL_TRAP_EN defined, opcodes 12–15 in RUN SHALL set err=1 (sticky until next accepted start or reset), suppress dec_valid, and go to DONE.
REQ-030 Without ID_ILLEGAL_TRAP_EN, opcodes 12–15 SHALL decode as ordinary ops and err SHALL be tied 0.

Structure
REQ-031 Shared package id_pkg SHALL hold opcode constants (NOP, HALT, LOOP, illegal range), field bit positions, and the FSM state enum.
REQ-032 Pass counter SHALL be a sub-module id_loop_counter (load, decrement, is_last).

Verification
REQ-033 Reset, start=1, alg_sel=3, block_count=1 -> JUMP with sel_pc=1, sel_dir=3; FILL; RUN; HALT word -> done pulse 1 cycle, busy=0.
REQ-034 block_count=3, program ends with LOOP -> exactly 3 JUMP cycles total, third LOOP falls through to HALT.
REQ-035 instruccion opcode=5 rd=2 rs=4 rt=9 in RUN -> next cycle opcode=5, rd=2, rs=4, rt=9, dec_valid=1.
REQ-036 stall=1 for 4 cycles in RUN -> pc_stall=1 for 4 cycles, outputs unchanged, resumes same sequence.
REQ-037 ID_ILLEGAL_TRAP_EN defined, opcode=13 -> err=1, dec_valid=0, done pulse; undefined -> dec_valid=1, err=0.
REQ-038 rst_n asserted during RUN -> same cycle all outputs 0, state IDLE; start=1 mid-run ignored.
